// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with registered read outputs.
// Define READ_BYPASS_EN to forward same-edge write data to a matching read port.
module reg_file_2r1w #(
   parameter int WIDTH    = 16,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 1
) (
   input  logic              CLK,
   input  logic              R,
   input  logic              WE,
   input  logic [ADDR_W-1:0] WA,
   input  logic [WIDTH-1:0]  WD,
   input  logic [ADDR_W-1:0] RA1,
   input  logic [ADDR_W-1:0] RA2,
   output logic [WIDTH-1:0]  RD1,
   output logic [WIDTH-1:0]  RD2
);

   localparam int NREG = 2 ** ADDR_W;

   logic [WIDTH-1:0] regs [NREG];
   logic [NREG-1:0]  we_dec;
   logic [WIDTH-1:0] rd1_next;
   logic [WIDTH-1:0] rd2_next;
   logic             wa_is_zero;

   assign wa_is_zero = (ZERO_REG != 0) && (WA == '0);

   always_comb begin
      we_dec = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         we_dec[i] = WE && !wa_is_zero && (WA == ADDR_W'(i));
      end
   end

   always_comb begin
      rd1_next = regs[RA1];
      rd2_next = regs[RA2];
`ifdef READ_BYPASS_EN
      if (WE && !wa_is_zero && (WA == RA1)) rd1_next = WD;
      if (WE && !wa_is_zero && (WA == RA2)) rd2_next = WD;
`endif
      // Forced last so register 0 reads as zero even from uninitialised storage.
      if ((ZERO_REG != 0) && (RA1 == '0)) rd1_next = '0;
      if ((ZERO_REG != 0) && (RA2 == '0)) rd2_next = '0;
   end

   always_ff @(posedge CLK) begin
      if (R) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         RD1 <= '0;
         RD2 <= '0;
      end else begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (we_dec[i]) regs[i] <= WD;
         end
         RD1 <= rd1_next;
         RD2 <= rd2_next;
      end
   end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w; expectations follow READ_BYPASS_EN when defined.
module tb_reg_file_2r1w;

   localparam int WIDTH  = 16;
   localparam int ADDR_W = 3;

   logic              CLK;
   logic              R;
   logic              WE;
   logic [ADDR_W-1:0] WA;
   logic [WIDTH-1:0]  WD;
   logic [ADDR_W-1:0] RA1;
   logic [ADDR_W-1:0] RA2;
   logic [WIDTH-1:0]  RD1;
   logic [WIDTH-1:0]  RD2;

   int passed = 0;
   int total  = 0;

   reg_file_2r1w #(
      .WIDTH    (WIDTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (1)
   ) dut (
      .CLK (CLK),
      .R   (R),
      .WE  (WE),
      .WA  (WA),
      .WD  (WD),
      .RA1 (RA1),
      .RA2 (RA2),
      .RD1 (RD1),
      .RD2 (RD2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [WIDTH-1:0] exp_same;

      R = 1'b1; WE = 1'b0; WA = '0; WD = '0; RA1 = '0; RA2 = '0;
      #1;

      // 1: reset for two edges, then read
      tick();
      tick();
      check("reset_rd1", RD1, 16'h0000);
      check("reset_rd2", RD2, 16'h0000);
      R = 1'b0; RA1 = 3'd5; RA2 = 3'd7;
      tick();
      check("post_reset_rd1", RD1, 16'h0000);
      check("post_reset_rd2", RD2, 16'h0000);

      // 2: write then read; WE=0 write must be ignored
      WE = 1'b1; WA = 3'd3; WD = 16'hA5A5; RA1 = 3'd5; RA2 = 3'd4;
      tick();
      WE = 1'b0; WA = 3'd3; WD = 16'hDEAD; RA1 = 3'd3; RA2 = 3'd4;
      tick();
      check("wr_rd_rd1", RD1, 16'hA5A5);
      check("wr_rd_rd2", RD2, 16'h0000);
      tick();
      check("we0_ignored", RD1, 16'hA5A5);

      // 3: same-edge write/read on both ports
      WE = 1'b1; WA = 3'd2; WD = 16'h00FF;
      tick();
      WE = 1'b1; WA = 3'd2; WD = 16'h1234; RA1 = 3'd2; RA2 = 3'd2;
`ifdef READ_BYPASS_EN
      exp_same = 16'h1234;
`else
      exp_same = 16'h00FF;
`endif
      tick();
      check("same_edge_rd1", RD1, exp_same);
      check("same_edge_rd2", RD2, exp_same);
      WE = 1'b0;
      tick();
      check("after_write_rd1", RD1, 16'h1234);
      check("after_write_rd2", RD2, 16'h1234);
      #3;
      check("hold_rd1", RD1, 16'h1234);

      // 4: zero register
      WE = 1'b1; WA = 3'd0; WD = 16'hFFFF; RA1 = 3'd0; RA2 = 3'd0;
      tick();
      check("zero_same_rd1", RD1, 16'h0000);
      check("zero_same_rd2", RD2, 16'h0000);
      WE = 1'b0;
      tick();
      check("zero_rd1", RD1, 16'h0000);
      check("zero_rd2", RD2, 16'h0000);

      // 5a: reset beats write, and clears read outputs
      RA1 = 3'd3; RA2 = 3'd3;
      tick();
      check("pre_reset_rd1", RD1, 16'hA5A5);
      R = 1'b1; WE = 1'b1; WA = 3'd6; WD = 16'hBEEF;
      tick();
      check("in_reset_rd1", RD1, 16'h0000);
      R = 1'b0; WE = 1'b0; RA1 = 3'd6; RA2 = 3'd3;
      tick();
      check("reset_prio_rd1", RD1, 16'h0000);
      check("reset_clr_rd2", RD2, 16'h0000);

      // 5b: fill 1..7, pulse reset, everything reads 0
      for (int i = 1; i < 8; i++) begin
         WE = 1'b1; WA = 3'(i); WD = 16'(16'h1111 * i);
         tick();
      end
      WE = 1'b0; RA1 = 3'd7; RA2 = 3'd1;
      tick();
      check("filled_rd1", RD1, 16'h7777);
      check("filled_rd2", RD2, 16'h1111);
      R = 1'b1;
      tick();
      R = 1'b0;
      for (int a = 0; a < 8; a++) begin
         RA1 = 3'(a); RA2 = 3'(7 - a);
         tick();
         check($sformatf("pulse_rd1_%0d", a), RD1, 16'h0000);
         check($sformatf("pulse_rd2_%0d", 7 - a), RD2, 16'h0000);
      end

      // 6: dual-port sweep
      for (int i = 1; i < 8; i++) begin
         WE = 1'b1; WA = 3'(i); WD = 16'(16'h0101 * i);
         tick();
      end
      WE = 1'b0;
      for (int k = 0; k < 8; k++) begin
         RA1 = 3'(k); RA2 = 3'(7 - k);
         tick();
         check($sformatf("sweep_rd1_%0d", k), RD1, 16'(16'h0101 * k));
         check($sformatf("sweep_rd2_%0d", 7 - k), RD2, 16'(16'h0101 * (7 - k)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
